// File: rtl/l1_cache_ctrl_param.sv
// MESI tag/state controller for a parametrised set-associative L1 with true-LRU replacement.
// Holds tags, coherence state and LRU ranks only; data movement is signalled to L2 as messages.
module l1_cache_ctrl_param #(
  parameter int ADDR_W    = 32,
  parameter int SETS_LOG2 = 6,
  parameter int WAYS      = 4,
  parameter int LINE_LOG2 = 6,
  parameter int CNT_W     = 32,
  localparam int LRU_W    = $clog2(WAYS),
  localparam int TAG_W    = ADDR_W - LINE_LOG2 - SETS_LOG2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd,
  input  logic [ADDR_W-1:0]            cmd_addr,
  output logic                         resp_valid,
  output logic                         resp_hit,
  output logic                         l2_valid,
  output logic [1:0]                   l2_cmd,
  output logic [ADDR_W-1:0]            l2_addr,
  input  logic [SETS_LOG2-1:0]         dbg_set,
  input  logic [LRU_W-1:0]             dbg_way,
  output logic [TAG_W+2+LRU_W-1:0]     dbg_line,
  output logic [CNT_W-1:0]             hits,
  output logic [CNT_W-1:0]             misses,
  output logic [CNT_W-1:0]             reads,
  output logic [CNT_W-1:0]             writes
);

  localparam int SETS = 1 << SETS_LOG2;

  localparam logic [2:0] CMD_READ      = 3'd0;
  localparam logic [2:0] CMD_WRITE     = 3'd1;
  localparam logic [2:0] CMD_SNOOP_INV = 3'd2;
  localparam logic [2:0] CMD_CLEAR     = 3'd3;
  localparam logic [2:0] CMD_SNOOP_RD  = 3'd4;

  typedef enum logic [2:0] {ST_SWEEP, ST_IDLE, ST_LOOKUP, ST_MSG2, ST_DONE} state_t;
  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_M = 2'd1, MESI_S = 2'd2, MESI_E = 2'd3} mesi_t;
  typedef enum logic [1:0] {L2_RETURNDATA = 2'd0, L2_WRITEBACK = 2'd1,
                            L2_READ = 2'd2, L2_RFO = 2'd3} l2_t;

  state_t                 state;
  logic [2:0]             cmd_q;
  logic [ADDR_W-1:LINE_LOG2] line_q;
  logic                   sweep_clear;
  logic [SETS_LOG2-1:0]   sweep_set;
  l2_t                    pend_cmd;

  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  mesi_t            mesi_mem [SETS][WAYS];
  logic [LRU_W-1:0] lru_mem  [SETS][WAYS];

  // Offset bits never matter: every line-level message is line aligned.
  logic unused_offset;
  assign unused_offset = ^cmd_addr[LINE_LOG2-1:0];

  logic [SETS_LOG2-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic [ADDR_W-1:0]    line_addr;
  assign idx       = line_q[LINE_LOG2 +: SETS_LOG2];
  assign tag       = line_q[ADDR_W-1 -: TAG_W];
  assign line_addr = {tag, idx, {LINE_LOG2{1'b0}}};
  assign cmd_ready = (state == ST_IDLE);

  logic             hit, found_inv;
  logic [LRU_W-1:0] hit_way, inv_way, max_way, victim, acc_way;
  logic [LRU_W-1:0] inv_lru, max_lru, acc_lru;
  mesi_t            hit_mesi, victim_mesi;
  logic [ADDR_W-1:0] victim_addr;

  // Tag match plus victim choice: prefer the oldest invalid way, else the oldest way overall.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    inv_way   = '0;
    inv_lru   = '0;
    max_way   = '0;
    max_lru   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && mesi_mem[idx][w] != MESI_I && tag_mem[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = LRU_W'(w);
      end
      if (mesi_mem[idx][w] == MESI_I && (!found_inv || lru_mem[idx][w] > inv_lru)) begin
        found_inv = 1'b1;
        inv_way   = LRU_W'(w);
        inv_lru   = lru_mem[idx][w];
      end
      if (w == 0 || lru_mem[idx][w] > max_lru) begin
        max_way = LRU_W'(w);
        max_lru = lru_mem[idx][w];
      end
    end
    victim      = found_inv ? inv_way : max_way;
    acc_way     = hit ? hit_way : victim;
    acc_lru     = lru_mem[idx][acc_way];
    hit_mesi    = mesi_mem[idx][hit_way];
    victim_mesi = mesi_mem[idx][victim];
    victim_addr = {tag_mem[idx][victim], idx, {LINE_LOG2{1'b0}}};
  end

  logic  wr_en, lru_upd, msg_valid, need_msg2, cmd_known;
  mesi_t new_mesi;
  l2_t   msg_cmd, fill_cmd;
  logic [ADDR_W-1:0] msg_addr;

  always_comb begin
    wr_en     = 1'b0;
    lru_upd   = 1'b0;
    msg_valid = 1'b0;
    need_msg2 = 1'b0;
    new_mesi  = MESI_I;
    msg_cmd   = L2_READ;
    fill_cmd  = (cmd_q == CMD_WRITE) ? L2_RFO : L2_READ;
    msg_addr  = line_addr;
    cmd_known = (cmd_q <= CMD_SNOOP_RD) && (cmd_q != CMD_CLEAR);
    case (cmd_q)
      CMD_READ, CMD_WRITE: begin
        wr_en   = 1'b1;
        lru_upd = 1'b1;
        if (hit) begin
          new_mesi = hit_mesi;
          if (cmd_q == CMD_WRITE) begin
            new_mesi = MESI_M;
            if (hit_mesi == MESI_S) begin
              msg_valid = 1'b1;
              msg_cmd   = L2_RFO;
            end
          end
        end else begin
          new_mesi  = (cmd_q == CMD_WRITE) ? MESI_M : MESI_E;
          msg_valid = 1'b1;
          if (victim_mesi == MESI_M) begin
            msg_cmd   = L2_WRITEBACK;
            msg_addr  = victim_addr;
            need_msg2 = 1'b1;
          end else begin
            msg_cmd = fill_cmd;
          end
        end
      end
      CMD_SNOOP_RD: begin
        if (hit) begin
          wr_en    = 1'b1;
          new_mesi = (hit_mesi == MESI_S) ? MESI_S : MESI_S;
          if (hit_mesi == MESI_M) begin
            msg_valid = 1'b1;
            msg_cmd   = L2_RETURNDATA;
          end
        end
      end
      CMD_SNOOP_INV: begin
        if (hit) begin
          wr_en    = 1'b1;
          new_mesi = MESI_I;
          if (hit_mesi == MESI_M) begin
            msg_valid = 1'b1;
            msg_cmd   = L2_WRITEBACK;
          end
        end
      end
      default: ;
    endcase
  end

  // Main sequencer: init/clear sweep, lookup and update, optional second message, response.
  always_ff @(posedge clk) begin
    resp_valid <= 1'b0;
    l2_valid   <= 1'b0;
    if (rst) begin
      state       <= ST_SWEEP;
      sweep_set   <= '0;
      sweep_clear <= 1'b0;
      cmd_q       <= '0;
      line_q      <= '0;
      pend_cmd    <= L2_READ;
      resp_hit    <= 1'b0;
      l2_cmd      <= '0;
      l2_addr     <= '0;
      hits        <= '0;
      misses      <= '0;
      reads       <= '0;
      writes      <= '0;
    end else begin
      case (state)
        ST_SWEEP: begin
          for (int w = 0; w < WAYS; w++) begin
            tag_mem[sweep_set][w]  <= '0;
            mesi_mem[sweep_set][w] <= MESI_I;
            lru_mem[sweep_set][w]  <= LRU_W'(WAYS - 1 - w);
          end
          sweep_set <= sweep_set + SETS_LOG2'(1);
          if (&sweep_set) begin
            if (sweep_clear) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
              resp_hit   <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q  <= cmd;
            line_q <= cmd_addr[ADDR_W-1:LINE_LOG2];
            if (cmd == CMD_CLEAR) begin
              state       <= ST_SWEEP;
              sweep_set   <= '0;
              sweep_clear <= 1'b1;
            end else begin
              state <= ST_LOOKUP;
            end
          end
        end
        ST_LOOKUP: begin
          if (wr_en) begin
            tag_mem[idx][acc_way]  <= tag;
            mesi_mem[idx][acc_way] <= new_mesi;
          end
          if (lru_upd) begin
            for (int w = 0; w < WAYS; w++) begin
              if (lru_mem[idx][w] < acc_lru) lru_mem[idx][w] <= lru_mem[idx][w] + LRU_W'(1);
            end
            lru_mem[idx][acc_way] <= '0;
          end
          if (cmd_q == CMD_READ)  reads  <= reads + CNT_W'(1);
          if (cmd_q == CMD_WRITE) writes <= writes + CNT_W'(1);
          if (lru_upd) begin
            if (hit) hits   <= hits + CNT_W'(1);
            else     misses <= misses + CNT_W'(1);
          end
          if (msg_valid) begin
            l2_valid <= 1'b1;
            l2_cmd   <= msg_cmd;
            l2_addr  <= msg_addr;
          end
          pend_cmd <= fill_cmd;
          if (need_msg2) begin
            state <= ST_MSG2;
          end else begin
            state      <= ST_DONE;
            resp_valid <= 1'b1;
            resp_hit   <= hit && cmd_known;
          end
        end
        ST_MSG2: begin
          l2_valid   <= 1'b1;
          l2_cmd     <= pend_cmd;
          l2_addr    <= line_addr;
          state      <= ST_DONE;
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_SWEEP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_line <= '0;
    else     dbg_line <= {tag_mem[dbg_set][dbg_way], mesi_mem[dbg_set][dbg_way],
                          lru_mem[dbg_set][dbg_way]};
  end

endmodule
